tz_mask_gen: RTL and testbench

//  Inverse of the trailing-zero counter: accepts a trailing-zero count N and builds,
//  by serial shifting, the WIDTH-bit lowest-set-bit mask (N zeros at LSB, a single 1
//  at bit N, zeros above). N==WIDTH yields all-zero. Sits downstream of count/encode

---
 rtl/tz_mask_gen.sv | 102 ++++++++++
 tb/tb_tz_mask_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tz_mask_gen.sv
// Regenerates the lowest-set-bit mask from a trailing-zero count by shifting a
// single 1 left n times; one transaction in flight with valid/ready on both sides.
module tz_mask_gen #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic             out_zero,
  output logic             out_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [WIDTH-1:0] SEED_C  = WIDTH'(1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] mask_r, mask_s;
  logic [CNT_W-1:0] rem_r, rem_s;
  logic             err_r, err_s;

  // Next-state logic: accept in IDLE, shift until remaining hits 1, hold until taken
  always_comb begin
    state_s = state_r;
    mask_s  = mask_r;
    rem_s   = rem_r;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          // Counts beyond WIDTH saturate so the single 1 is shifted fully out
          err_s  = (in_count > WIDTH_C);
          rem_s  = (in_count > WIDTH_C) ? WIDTH_C : in_count;
          mask_s = SEED_C;
          if (((in_count > WIDTH_C) ? WIDTH_C : in_count) == {CNT_W{1'b0}}) begin
            state_s = HOLD;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        mask_s = mask_r << 1;
        rem_s  = rem_r - ONE_C;
        if (rem_r == ONE_C) begin
          state_s = HOLD;
        end else begin
          state_s = SHIFT;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      mask_r  <= {WIDTH{1'b0}};
      rem_r   <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      mask_r  <= mask_s;
      rem_r   <= rem_s;
      err_r   <= err_s;
    end
  end

  // Result is only visible while held; everything reads zero otherwise
  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = (state_r == HOLD);
  assign out_mask  = (state_r == HOLD) ? mask_r : {WIDTH{1'b0}};
  assign out_zero  = (state_r == HOLD) && (mask_r == {WIDTH{1'b0}});
  assign out_err   = (state_r == HOLD) && err_r;

endmodule

// File: tb/tb_tz_mask_gen.sv
// Directed bench for tz_mask_gen (WIDTH=4, CNT_W=3): latency, mask values,
// saturation, backpressure and mid-transaction reset.
module tb_tz_mask_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_count;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_mask;
  logic       out_zero;
  logic       out_err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  tz_mask_gen #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_zero(out_zero), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Accept cnt, verify out_valid stays low for n cycles, then check the held result
  // and complete the handshake. Called at a negedge with the DUT in IDLE.
  task automatic txn(input string tag, input logic [2:0] cnt, input logic [3:0] em,
                     input logic ez, input logic ee, input int n, input logic early_ready);
    chk({tag, "_ready_before"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_count = cnt;
    out_ready = early_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_valid_low"}, out_valid, 1'b0);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_mask_gated"}, out_mask, 4'b0000);
      @(posedge clk);
    end
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_mask"}, out_mask, em);
    chk({tag, "_zero"}, out_zero, ez);
    chk({tag, "_err"}, out_err, ee);
    chk({tag, "_in_ready_hold"}, in_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_ready_after"}, in_ready, 1'b1);
    chk({tag, "_mask_after"}, out_mask, 4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_count = 3'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_mask", out_mask, 4'b0000);
    chk("rst_out_zero", out_zero, 1'b0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_busy", busy, 1'b0);

    txn("n0", 3'd0, 4'b0001, 1'b0, 1'b0, 0, 1'b0);
    txn("n2", 3'd2, 4'b0100, 1'b0, 1'b0, 2, 1'b1);
    txn("n1", 3'd1, 4'b0010, 1'b0, 1'b0, 1, 1'b0);
    txn("n3", 3'd3, 4'b1000, 1'b0, 1'b0, 3, 1'b0);
    txn("n4", 3'd4, 4'b0000, 1'b1, 1'b0, 4, 1'b0);
    txn("n6", 3'd6, 4'b0000, 1'b1, 1'b1, 4, 1'b0);
    txn("n7", 3'd7, 4'b0000, 1'b1, 1'b1, 4, 1'b0);

    // Backpressure: a second count is offered throughout HOLD but must wait for IDLE
    in_valid = 1'b1;
    in_count = 3'd3;
    @(posedge clk);
    #1 in_count = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_shift_valid", out_valid, 1'b0);
      @(posedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_mask", out_mask, 4'b1000);
      chk("bp_hold_in_ready", in_ready, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_valid", out_valid, 1'b0);
    chk("bp_idle_ready", in_ready, 1'b1);
    chk("bp_idle_busy", busy, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_shift", out_valid, 1'b0);
    chk("bp_second_busy", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_second_mask", out_mask, 4'b0010);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_second_drop", out_valid, 1'b0);

    // Reset in the middle of a shift discards the transaction
    in_valid = 1'b1;
    in_count = 3'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rs_busy_pre", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rs_busy", busy, 1'b0);
    chk("rs_out_valid", out_valid, 1'b0);
    chk("rs_out_mask", out_mask, 4'b0000);
    chk("rs_in_ready", in_ready, 1'b1);
    txn("rs_n1", 3'd1, 4'b0010, 1'b0, 1'b0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
